dpe_ingress_arbiter: RTL

//   Packet-granular arbiter that shares the single DPE datapath between the
//   CPU and the four Ethernet ingress streams. It watches each source's

---
 rtl/dpe_ingress_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/dpe_ingress_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dpe_ingress_arbiter
// Purpose  : Packet-granular arbiter sharing the DPE datapath between the CPU
//            (source 0) and the Ethernet ingress streams (sources 1..N_SRC-1).
//            One source is granted per packet and the grant is held until
//            that packet's tlast beat handshakes. Also provides the FCR
//            pause/idle handshake towards CSR.
// Ports    : clk        - datapath clock
//            rst        - synchronous reset, active-high
//            pause      - stop granting new packets
//            in_tvalid  - per-source tvalid
//            in_tlast   - per-source tlast
//            out_tready - tready of the muxed stream
//            grant      - one-hot grant (per-source tready gating)
//            grant_idx  - binary index of the granted source
//            grant_vld  - a packet grant is active
//            idle       - no packet in flight
//            oversize   - 1-cycle pulse when a packet reaches MAX_BEATS beats
// Config   : DPE_ARB_CPU_PRIO_EN - when defined, source 0 wins every
//            arbitration; sources 1..N_SRC-1 round-robin among themselves.
// Revision : 1.0 - initial release
// ============================================================================
module dpe_ingress_arbiter #(
   parameter int N_SRC     = 5,
   parameter int MAX_BEATS = 2048
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       pause,
   input  logic [N_SRC-1:0]           in_tvalid,
   input  logic [N_SRC-1:0]           in_tlast,
   input  logic                       out_tready,
   output logic [N_SRC-1:0]           grant,
   output logic [$clog2(N_SRC)-1:0]   grant_idx,
   output logic                       grant_vld,
   output logic                       idle,
   output logic                       oversize
);

   localparam int IW = $clog2(N_SRC);
   localparam int PW = IW + 1;                 // scan position needs headroom before wrap
   localparam int CW = $clog2(MAX_BEATS + 1);

   localparam logic [0:0]    c_ST_IDLE  = 1'b0;
   localparam logic [0:0]    c_ST_BUSY  = 1'b1;
   localparam logic [IW-1:0] c_LAST_IDX = IW'(N_SRC - 1);
   localparam logic [PW-1:0] c_NSRC_P   = PW'(N_SRC);
   localparam logic [CW-1:0] c_MAX_CNT  = CW'(MAX_BEATS);
   localparam logic [CW-1:0] c_PRE_MAX  = CW'(MAX_BEATS - 1);
`ifdef DPE_ARB_CPU_PRIO_EN
   localparam logic [IW-1:0] c_RR_WRAP   = IW'(1);   // rr pointer never rests on the CPU
   localparam logic [PW-1:0] c_NSRC_M1_P = PW'(N_SRC - 1);
`else
   localparam logic [IW-1:0] c_RR_WRAP   = '0;
`endif

   logic [0:0]       r_state, w_state_nxt;
   logic [N_SRC-1:0] r_grant, w_grant_nxt;
   logic [IW-1:0]    r_grant_idx, w_grant_idx_nxt;
   logic             r_grant_vld, w_grant_vld_nxt;
   logic             r_idle;
   logic             r_oversize, w_oversize_nxt;
   logic [IW-1:0]    r_rr_ptr, w_rr_ptr_nxt;
   logic [CW-1:0]    r_beat_cnt, w_beat_cnt_nxt;

   logic             w_beat, w_last_beat, w_rearb;
   logic [IW-1:0]    w_rr_next, w_scan_base, w_arb_idx;
   logic [PW-1:0]    w_scan_pos;
   logic             w_arb_found;

   assign w_beat      = r_grant_vld & out_tready & in_tvalid[r_grant_idx];
   assign w_last_beat = w_beat & in_tlast[r_grant_idx];
   assign w_rearb     = ~pause & w_arb_found;

   // Round-robin pointer that takes effect once the current packet ends.
   always_comb begin
      if (r_grant_idx == c_LAST_IDX) w_rr_next = c_RR_WRAP;
      else                           w_rr_next = r_grant_idx + 1'b1;
   end

   // Request scan. In BUSY the scan starts from the post-packet pointer so a
   // back-to-back grant on the tlast beat already honours the rotation; the
   // finishing source stays eligible but is scanned last.
   always_comb begin
      w_scan_base = (r_state == c_ST_BUSY) ? w_rr_next : r_rr_ptr;
      w_arb_found = 1'b0;
      w_arb_idx   = '0;
      w_scan_pos  = '0;
`ifdef DPE_ARB_CPU_PRIO_EN
      if (w_scan_base == '0) w_scan_base = c_RR_WRAP;
      if (in_tvalid[0]) begin
         w_arb_found = 1'b1;
      end else begin
         for (int off = 0; off < N_SRC - 1; off++) begin
            w_scan_pos = {1'b0, w_scan_base} + PW'(off);
            if (w_scan_pos >= c_NSRC_P) w_scan_pos = w_scan_pos - c_NSRC_M1_P;
            if (!w_arb_found && in_tvalid[w_scan_pos[IW-1:0]]) begin
               w_arb_found = 1'b1;
               w_arb_idx   = w_scan_pos[IW-1:0];
            end
         end
      end
`else
      for (int off = 0; off < N_SRC; off++) begin
         w_scan_pos = {1'b0, w_scan_base} + PW'(off);
         if (w_scan_pos >= c_NSRC_P) w_scan_pos = w_scan_pos - c_NSRC_P;
         if (!w_arb_found && in_tvalid[w_scan_pos[IW-1:0]]) begin
            w_arb_found = 1'b1;
            w_arb_idx   = w_scan_pos[IW-1:0];
         end
      end
`endif
   end

   // State register (outputs are registered alongside the state).
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= c_ST_IDLE;
         r_grant     <= '0;
         r_grant_idx <= '0;
         r_grant_vld <= 1'b0;
         r_idle      <= 1'b1;
         r_oversize  <= 1'b0;
         r_rr_ptr    <= '0;
         r_beat_cnt  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_grant     <= w_grant_nxt;
         r_grant_idx <= w_grant_idx_nxt;
         r_grant_vld <= w_grant_vld_nxt;
         r_idle      <= ~w_grant_vld_nxt;
         r_oversize  <= w_oversize_nxt;
         r_rr_ptr    <= w_rr_ptr_nxt;
         r_beat_cnt  <= w_beat_cnt_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: if (w_rearb) w_state_nxt = c_ST_BUSY;
         c_ST_BUSY: if (w_last_beat && !w_rearb) w_state_nxt = c_ST_IDLE;
         default:   w_state_nxt = c_ST_IDLE;
      endcase
   end

   // Output / datapath next values.
   always_comb begin
      w_grant_nxt     = r_grant;
      w_grant_idx_nxt = r_grant_idx;
      w_grant_vld_nxt = r_grant_vld;
      w_rr_ptr_nxt    = r_rr_ptr;
      w_beat_cnt_nxt  = r_beat_cnt;
      w_oversize_nxt  = 1'b0;
      case (r_state)
         c_ST_IDLE: begin
            if (w_rearb) begin
               w_grant_nxt     = N_SRC'(1) << w_arb_idx;
               w_grant_idx_nxt = w_arb_idx;
               w_grant_vld_nxt = 1'b1;
               w_beat_cnt_nxt  = '0;
            end
         end
         c_ST_BUSY: begin
            if (w_beat) begin
               if (r_beat_cnt != c_MAX_CNT) w_beat_cnt_nxt = r_beat_cnt + 1'b1;
               // Only the beat that lands exactly on MAX_BEATS can fire, and
               // saturation keeps it from firing again in the same packet.
               if (!in_tlast[r_grant_idx] && r_beat_cnt == c_PRE_MAX) w_oversize_nxt = 1'b1;
            end
            if (w_last_beat) begin
               w_rr_ptr_nxt   = w_rr_next;
               w_beat_cnt_nxt = '0;
               if (w_rearb) begin
                  w_grant_nxt     = N_SRC'(1) << w_arb_idx;
                  w_grant_idx_nxt = w_arb_idx;
                  w_grant_vld_nxt = 1'b1;
               end else begin
                  w_grant_nxt     = '0;
                  w_grant_vld_nxt = 1'b0;
               end
            end
         end
         default: begin
            w_grant_nxt     = '0;
            w_grant_vld_nxt = 1'b0;
         end
      endcase
   end

   assign grant     = r_grant;
   assign grant_idx = r_grant_idx;
   assign grant_vld = r_grant_vld;
   assign idle      = r_idle;
   assign oversize  = r_oversize;

endmodule
`default_nettype wire
